// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sin/cos generator.
//   NCO_LATENCY       : ClkEn cycles from accumulator value to output sample
//   NUM_RD_PORTS      : quarter-wave ROM read ports (0 = sine, 1 = cosine)
//   nco_amp()         : output amplitude A = 2^(OUT_W-1)-1
//   sin_quarter_entry : LUT[k] = round(A * sin(pi/2 * (k+0.5) / 2^LUT_AW))
package nco_pkg;

  localparam int NCO_LATENCY  = 3;
  localparam int NUM_RD_PORTS = 2;

  // pi/2 in Q2.30 fixed point (0x6487ED51)
  localparam longint HALF_PI_Q30 = 64'sd1686629713;
  localparam int     FRAC_BITS   = 30;

  function automatic longint nco_amp(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  // Integer-only Taylor series so the table folds at elaboration on any tool.
  // Eight terms keep the error around 1e-8 at pi/2, far below one output LSB.
  // Angle is sampled at k+0.5, which makes quadrant mirroring exact.
  function automatic int sin_quarter_entry(input int k, input int lut_aw, input int out_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (HALF_PI_Q30 * (2 * longint'(k) + 1)) >>> (lut_aw + 1);
    x2   = (x * x) >>> FRAC_BITS;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> FRAC_BITS) / longint'(2 * n * (2 * n + 1));
      sum  = sum + term;
    end
    amp = nco_amp(out_w);
    return int'((amp * sum + (64'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/nco_sincos_gen_if.sv
// Control/sample bus of the NCO.
//   master : drives ClkEn, FreqWord, FreqLoad, PhaseOffset, PhaseSync; sees samples
//   slave  : the NCO; produces Sine, Cosine, OutValid
interface nco_sincos_gen_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 10
);
  logic                      ClkEn;
  logic [PHASE_W-1:0]        FreqWord;
  logic                      FreqLoad;
  logic [PHASE_W-1:0]        PhaseOffset;
  logic                      PhaseSync;
  logic signed [OUT_W-1:0]   Sine;
  logic signed [OUT_W-1:0]   Cosine;
  logic                      OutValid;

  modport master (
    output ClkEn, FreqWord, FreqLoad, PhaseOffset, PhaseSync,
    input  Sine, Cosine, OutValid
  );

  modport slave (
    input  ClkEn, FreqWord, FreqLoad, PhaseOffset, PhaseSync,
    output Sine, Cosine, OutValid
  );
endinterface

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine ROM with NUM_RD_PORTS registered read ports.
//   Clock, ResetN : clock, async active-low reset (clears read registers)
//   ClkEn         : shared read enable; registers hold when low
//   rd_addr[p]    : read address of port p
//   rd_data[p]    : unsigned magnitude, OUT_W-1 bits, one cycle after address
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 10
) (
  input  logic                                   Clock,
  input  logic                                   ResetN,
  input  logic                                   ClkEn,
  input  logic [NUM_RD_PORTS-1:0][LUT_AW-1:0]    rd_addr,
  output logic [NUM_RD_PORTS-1:0][OUT_W-2:0]     rd_data
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [OUT_W-2:0] lut_tbl [DEPTH];

  // Each entry is a localparam so the table is a pure constant.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    localparam logic [OUT_W-2:0] ENTRY = (OUT_W-1)'(sin_quarter_entry(k, LUT_AW, OUT_W));
    assign lut_tbl[k] = ENTRY;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rd_data <= '0;
    end else if (ClkEn) begin
      for (int p = 0; p < NUM_RD_PORTS; p++)
        rd_data[p] <= lut_tbl[rd_addr[p]];
    end
  end

endmodule

// File: rtl/nco_sincos_gen.sv
// Numerically-controlled oscillator producing an I/Q (cos/sin) pair.
//   Clock, ResetN : clock, async active-low reset
//   bus (slave)   : ClkEn sample enable, FreqWord/FreqLoad deferred frequency
//                   update, PhaseOffset live offset, PhaseSync deferred
//                   accumulator clear; Sine/Cosine signed samples, OutValid
// Pipeline (all stages advance on ClkEn only):
//   0: acc        phase accumulator
//   1: ph         top LUT_AW+2 bits of acc + PhaseOffset
//   2: rd_data    ROM reads for sin and cos quadrants, neg_q sign flags
//   3: Sine/Cos   sign applied
module nco_sincos_gen
  import nco_pkg::*;
#(
  parameter int                 PHASE_W   = 32,
  parameter int                 LUT_AW    = 8,
  parameter int                 OUT_W     = 10,
  parameter logic [PHASE_W-1:0] FREQ_INIT = '0
) (
  input  logic              Clock,
  input  logic              ResetN,
  nco_sincos_gen_if.slave   bus
);

  localparam int PH_W = LUT_AW + 2;

  // ---------------- stage 0: accumulator and pending updates --------------
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] freq_active;
  logic [PHASE_W-1:0] freq_pend;
  logic               load_pend;
  logic               sync_pend;

  // A strobe arriving on an enabled edge re-arms the flag, so set wins.
  // The increment always uses freq_active from before this edge, which makes
  // a simultaneous sync+load give acc=0 now and acc=new word next sample.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      acc         <= '0;
      freq_active <= FREQ_INIT;
      freq_pend   <= '0;
      load_pend   <= 1'b0;
      sync_pend   <= 1'b0;
    end else begin
      if (bus.FreqLoad)
        freq_pend <= bus.FreqWord;
      if (bus.ClkEn) begin
        acc <= sync_pend ? '0 : acc + freq_active;
        if (load_pend)
          freq_active <= freq_pend;
      end
      load_pend <= bus.FreqLoad  | (load_pend & ~bus.ClkEn);
      sync_pend <= bus.PhaseSync | (sync_pend & ~bus.ClkEn);
    end
  end

  // ---------------- stage 1: offset and phase truncation ------------------
  logic [PHASE_W-1:0] ph_sum;
  logic [PH_W-1:0]    ph;
  logic               unused_ph_lsbs;

  assign ph_sum         = acc + bus.PhaseOffset;
  assign unused_ph_lsbs = &{1'b0, ph_sum[PHASE_W-PH_W-1:0]};

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)        ph <= '0;
    else if (bus.ClkEn) ph <= ph_sum[PHASE_W-1 -: PH_W];
  end

  // ---------------- stage 2: quadrant mapping and ROM reads ---------------
  // Cosine uses its own read port with the quadrant advanced by one, which is
  // cos(x) = sin(x + pi/2). Odd quadrants read the table mirrored.
  logic [1:0]                              q;
  logic [1:0]                              qc;
  logic [LUT_AW-1:0]                       idx;
  logic [NUM_RD_PORTS-1:0][LUT_AW-1:0]     rd_addr;
  logic [NUM_RD_PORTS-1:0][OUT_W-2:0]      rd_data;
  logic [NUM_RD_PORTS-1:0]                 neg_q;

  assign q          = ph[PH_W-1 -: 2];
  assign qc         = q + 2'd1;
  assign idx        = ph[LUT_AW-1:0];
  assign rd_addr[0] = q[0]  ? ~idx : idx;
  assign rd_addr[1] = qc[0] ? ~idx : idx;

  nco_quarter_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .ClkEn   (bus.ClkEn),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)        neg_q <= '0;
    else if (bus.ClkEn) neg_q <= {qc[1], q[1]};
  end

  // ---------------- stage 3: sign application -----------------------------
  // Magnitudes never exceed A, so negation cannot overflow OUT_W bits.
  logic signed [OUT_W-1:0] mag_s;
  logic signed [OUT_W-1:0] mag_c;

  assign mag_s = signed'({1'b0, rd_data[0]});
  assign mag_c = signed'({1'b0, rd_data[1]});

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      bus.Sine   <= '0;
      bus.Cosine <= '0;
    end else if (bus.ClkEn) begin
      bus.Sine   <= neg_q[0] ? -mag_s : mag_s;
      bus.Cosine <= neg_q[1] ? -mag_c : mag_c;
    end
  end

  // ---------------- valid tracking ----------------------------------------
  // fill[i] marks that stage i+1 holds a real sample; en_q marks that the
  // last edge actually advanced the pipeline, so OutValid pulses once per
  // new sample and stays low on frozen cycles.
  logic [NCO_LATENCY-1:0] fill;
  logic                   en_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      fill <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= bus.ClkEn;
      if (bus.ClkEn)
        fill <= {fill[NCO_LATENCY-2:0], 1'b1};
    end
  end

  assign bus.OutValid = fill[NCO_LATENCY-1] & en_q;

endmodule
